// File: rtl/mem_req_master.sv
// CPU-side request queue feeding the main memory rd_mem/wr_mem/ready_mem interface.
// One access in flight at a time; each strobe is held HOLD_CYCLES cycles, then a response cycle.
module mem_req_master #(
  parameter int AWIDTH      = 9,
  parameter int DWIDTH      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              wr_done,
  output logic              busy,
  output logic              proto_err,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              ready_mem
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] HOLD_M1 = 3'(HOLD_CYCLES - 1);

  typedef struct packed {
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, RD_ACC, WR_ACC, RESP} state_t;

  req_t          fifo [FIFO_DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, in_acc, acc_end;
  state_t        state_q, state_d;
  logic [2:0]    hold_q, hold_d;
  logic          cur_we;

  assign req_ready  = (count != (PW+1)'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign head       = fifo[rd_ptr];
  assign in_acc     = (state_q == RD_ACC) || (state_q == WR_ACC);
  assign acc_end    = in_acc && (state_d == RESP);
  assign resp_valid = (state_q == RESP) && !cur_we;
  assign wr_done    = (state_q == RESP) && cur_we;
  assign busy       = (state_q != IDLE) || (count != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count != '0 && ready_mem) begin
        pop     = 1'b1;
        hold_d  = HOLD_M1;
        state_d = head.we ? WR_ACC : RD_ACC;
      end
      RD_ACC, WR_ACC: begin
        if (hold_q == 3'd0) state_d = RESP;
        else                hold_d  = hold_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Queue storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_we     <= 1'b0;
      rd_mem     <= 1'b0;
      wr_mem     <= 1'b0;
      addr_mem   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count   <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        cur_we    <= head.we;
        addr_mem  <= head.addr;
        mem_wdata <= head.wdata;
        rd_mem    <= !head.we;
        wr_mem    <= head.we;
      end
      // Memory drove data_out on the preceding negedge, so capture on the last strobe edge.
      if (acc_end) begin
        rd_mem <= 1'b0;
        wr_mem <= 1'b0;
        if (state_q == RD_ACC) resp_rdata <= mem_rdata;
      end
      if (in_acc && ready_mem) proto_err <= 1'b1;
    end
  end

endmodule
